// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM encoding, command bytes
// and default timing for a 50 MHz system clock.
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RTS   = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4,
      ST_ACK   = 3'd5,
      ST_REL   = 3'd6
   } state_t;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] RSP_ACK     = 8'hFA;

   localparam int RTS_CYCLES_DEF     = 5000;
   localparam int TIMEOUT_CYCLES_DEF = 1_000_000;
   localparam int FILT_LEN_DEF       = 8;

endpackage

// File: rtl/ps2_host_tx_line_filter.sv
// PS/2 line conditioner: 2-flop synchroniser, FILT_LEN-deep agreement filter and a
// one-cycle pulse on every filtered 1->0 transition.
module ps2_line_filter
   import ps2_host_tx_pkg::*;
#(
   parameter int FILT_LEN = FILT_LEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic line_in,
   output logic level,
   output logic fall_tick
);

   logic [1:0]          sync_q, sync_d;
   logic [FILT_LEN-1:0] hist_q, hist_d;
   logic                level_q, level_d;
   logic                fall_q, fall_d;

   always_comb begin
      sync_d  = {sync_q[0], line_in};
      hist_d  = {hist_q[FILT_LEN-2:0], sync_q[1]};
      level_d = level_q;
      // Level only moves when the whole window agrees; mixed windows hold it.
      if (&hist_q) begin
         level_d = 1'b1;
      end else if (hist_q == '0) begin
         level_d = 1'b0;
      end
      fall_d = level_q & ~level_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q  <= '1;
         hist_q  <= '1;
         level_q <= 1'b1;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         hist_q  <= hist_d;
         level_q <= level_d;
         fall_q  <= fall_d;
      end
   end

   assign level     = level_q;
   assign fall_tick = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, start, 8 data bits LSB first,
// odd parity, stop, then waits for the device ack and line release.
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int RTS_CYCLES     = RTS_CYCLES_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int FILT_LEN       = FILT_LEN_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       wr_ps2,
   input  logic [7:0] din,
   inout  wire        ps2c,
   inout  wire        ps2d,
   output logic       tx_idle,
   output logic       tx_done_tick,
   output logic       tx_err
);

   localparam int CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RTS_LAST = CNT_W'(RTS_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [8:0]       sh_q, sh_d;
   logic [3:0]       n_q, n_d;
   logic             c_oe_q, c_oe_d;
   logic             d_oe_q, d_oe_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [1:0]       d_sync_q, d_sync_d;
   logic             c_level;
   logic             c_fall;

   ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_c_filt (
      .clk       (clk),
      .rst       (rst),
      .line_in   (ps2c),
      .level     (c_level),
      .fall_tick (c_fall)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      n_d      = n_q;
      c_oe_d   = c_oe_q;
      d_oe_d   = d_oe_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      d_sync_d = {d_sync_q[0], ps2d};

      case (state_q)
         ST_IDLE: begin
            c_oe_d = 1'b0;
            d_oe_d = 1'b0;
            if (wr_ps2) begin
               state_d = ST_RTS;
               cnt_d   = '0;
               sh_d    = {~^din, din};
               n_d     = '0;
               c_oe_d  = 1'b1;
            end
         end
         ST_RTS: begin
            if (cnt_q == RTS_LAST) begin
               state_d = ST_START;
               cnt_d   = '0;
               c_oe_d  = 1'b0;
               d_oe_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            // Every device-clocked state shares one watchdog started at ps2c release.
            if (cnt_q == TO_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               c_oe_d  = 1'b0;
               d_oe_d  = 1'b0;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
               case (state_q)
                  ST_START: begin
                     if (c_fall) begin
                        state_d = ST_DATA;
                        d_oe_d  = ~sh_q[0];
                        sh_d    = {1'b0, sh_q[8:1]};
                        n_d     = 4'd1;
                     end
                  end
                  ST_DATA: begin
                     if (c_fall) begin
                        if (n_q == 4'd9) begin
                           state_d = ST_STOP;
                           d_oe_d  = 1'b0;
                        end else begin
                           d_oe_d = ~sh_q[0];
                           sh_d   = {1'b0, sh_q[8:1]};
                           n_d    = n_q + 4'd1;
                        end
                     end
                  end
                  ST_STOP: begin
                     if (c_fall) begin
                        state_d = ST_ACK;
                     end
                  end
                  ST_ACK: begin
                     // Entered on the 11th fall; the device holds ack low across it.
                     if (d_sync_q[1]) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        err_d   = 1'b1;
                     end else begin
                        state_d = ST_REL;
                     end
                  end
                  ST_REL: begin
                     if (c_level && d_sync_q[1]) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                     end
                  end
                  default: begin
                     state_d = ST_IDLE;
                  end
               endcase
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         sh_q     <= '0;
         n_q      <= '0;
         c_oe_q   <= 1'b0;
         d_oe_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         d_sync_q <= 2'b11;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         n_q      <= n_d;
         c_oe_q   <= c_oe_d;
         d_oe_q   <= d_oe_d;
         done_q   <= done_d;
         err_q    <= err_d;
         d_sync_q <= d_sync_d;
      end
   end

   assign ps2c         = c_oe_q ? 1'b0 : 1'bz;
   assign ps2d         = d_oe_q ? 1'b0 : 1'bz;
   assign tx_idle      = (state_q == ST_IDLE);
   assign tx_done_tick = done_q;
   assign tx_err       = err_q;

endmodule
